mem_bridge: RTL

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge_if.sv | 20 ++
 rtl/mem_bridge.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_bridge_if.sv
// CPU-side byte bus of the SRAM bridge.
// The requester holds req and its payload until the one-cycle ready pulse.
interface mem_bridge_if;
    logic [19:0] address;
    logic        req;
    logic        we;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        ready;

    modport master (
        output address, req, we, i_data,
        input  o_data, ready
    );

    modport slave (
        input  address, req, we, i_data,
        output o_data, ready
    );
endinterface

// File: rtl/mem_bridge.sv
// Byte-wide CPU to 16-bit async SRAM bridge with a one-word read line buffer.
// Writes go straight to SRAM and patch the buffer when it holds the same word.
module mem_bridge #(
    parameter int WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    mem_bridge_if.slave bus,
    output logic [18:0] sram_addr,
    input  logic [15:0] sram_din,
    output logic [15:0] sram_dout,
    output logic        sram_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);
    typedef enum logic [2:0] {
        IDLE, HIT, RACC, RDONE, WSETUP, WPULSE, WDONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [19:0] addr_q;
    logic [7:0]  data_q;
    logic        buf_valid;
    logic [18:0] buf_tag;
    logic [15:0] buf_word;
    logic        hit, last;
    logic [7:0]  buf_byte;

    assign hit      = buf_valid && (buf_tag == bus.address[19:1]);
    assign last     = (cnt == 4'd0);
    assign buf_byte = addr_q[0] ? buf_word[15:8] : buf_word[7:0];

    assign sram_addr = addr_q[19:1];
    assign sram_dout = {data_q, data_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= 20'd0;
            data_q <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            // Payload is frozen here; later bus changes are ignored
            if (state == IDLE && bus.req) begin
                addr_q <= bus.address;
                data_q <= bus.i_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= 19'd0;
            buf_word  <= 16'd0;
        end else if (state == RACC && last) begin
            buf_valid <= 1'b1;
            buf_tag   <= addr_q[19:1];
            buf_word  <= sram_din;
        end else if (state == WPULSE && last && buf_valid
                     && buf_tag == addr_q[19:1]) begin
            if (addr_q[0]) buf_word[15:8] <= data_q;
            else           buf_word[7:0]  <= data_q;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bus.we) begin
                        state_nx = WSETUP;
                    end else if (hit) begin
                        state_nx = HIT;
                    end else begin
                        state_nx = RACC;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            HIT, RDONE, WDONE: state_nx = IDLE;
            RACC: begin
                if (last) state_nx = RDONE;
                else      cnt_nx   = cnt - 4'd1;
            end
            WSETUP: begin
                state_nx = WPULSE;
                cnt_nx   = CNT_INIT;
            end
            WPULSE: begin
                if (last) state_nx = WDONE;
                else      cnt_nx   = cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_oe    = 1'b0;
        bus.ready  = 1'b0;
        bus.o_data = 8'h00;
        unique case (state)
            HIT, RDONE: begin
                bus.ready  = 1'b1;
                bus.o_data = buf_byte;
            end
            RACC: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_ub_n = 1'b0;
            end
            // Driver stays on through WDONE so data holds past the we_n rise
            WSETUP, WPULSE, WDONE: begin
                sram_ce_n = 1'b0;
                sram_oe   = 1'b1;
                sram_lb_n = addr_q[0];
                sram_ub_n = ~addr_q[0];
                sram_we_n = (state != WPULSE);
                bus.ready = (state == WDONE);
            end
            default: ;
        endcase
    end
endmodule
